// File: rtl/regfile_read_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_read_arbiter_if
// Description : Bundle of signals between the register-file read arbiter,
//               its four read clients and the 32:1 read mux.
//               master : the client/mux side (drives requests, rsp_ready,
//                        mux_out)
//               slave  : the arbiter side (drives grants, mux_select,
//                        responses, busy)
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_read_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREQ   = 4
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ-1:0]        req_ready;
    logic [ADDR_W-1:0]      mux_select;
    logic [DATA_W-1:0]      mux_out;
    logic [NREQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]      rsp_data;
    logic [NREQ-1:0]        rsp_ready;
    logic                   busy;

    modport slave (
        input  req_valid, req_addr, mux_out, rsp_ready,
        output req_ready, mux_select, rsp_valid, rsp_data, busy
    );

    modport master (
        output req_valid, req_addr, mux_out, rsp_ready,
        input  req_ready, mux_select, rsp_valid, rsp_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/regfile_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_read_arbiter
// Description : Round-robin sharing of the register file's single read port
//               among four requesters. A grant latches the select, the next
//               cycle captures the mux output, then the result is offered
//               to the granted requester until it accepts.
// Ports       : clk   - rising-edge clock
//               reset - synchronous active-high reset
//               bus   - regfile_read_arbiter_if.slave (requests, grants,
//                       mux select/data, responses, busy)
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_read_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREQ   = 4    // fixed at 4: pointer and ids are 2 bits
) (
    input  logic                          clk,
    input  logic                          reset,
    regfile_read_arbiter_if.slave         bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        RESP    = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_ptr;
    logic [1:0]        r_gid;
    logic [ADDR_W-1:0] r_sel;
    logic [DATA_W-1:0] r_data;

    logic [1:0]        w_win;
    logic              w_found;
    logic [ADDR_W-1:0] w_win_addr;
    logic              w_rsp_done;
    logic              w_arb_en;
    logic              w_grant;

    // Only the granted requester's rsp_ready can complete the response.
    assign w_rsp_done = (r_state == RESP) && bus.rsp_ready[r_gid];
    assign w_arb_en   = (r_state == IDLE) || w_rsp_done;
    // Reset dominates: no request is consumed in a reset cycle.
    assign w_grant    = w_arb_en && w_found && !reset;

    // Round-robin scan from r_ptr. Iterating downwards lets the smallest
    // offset from r_ptr be the last (winning) assignment.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req_valid[r_ptr + 2'(i)]) begin
                w_found = 1'b1;
                w_win   = r_ptr + 2'(i);
            end
        end
    end

    always_comb begin
        w_win_addr = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_win == 2'(k)) begin
                w_win_addr = bus.req_addr[k*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_found) w_state_nxt = CAPTURE;
            CAPTURE: w_state_nxt = RESP;
            RESP:    if (w_rsp_done) w_state_nxt = w_found ? CAPTURE : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= 2'd0;
            r_gid   <= 2'd0;
            r_sel   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_sel <= w_win_addr;
                r_gid <= w_win;
                r_ptr <= w_win + 2'd1;
            end
            // mux_out has had a full cycle to settle on the new select.
            if (r_state == CAPTURE) begin
                r_data <= bus.mux_out;
            end
        end
    end

    assign bus.req_ready  = w_grant ? (NREQ'(1) << w_win) : '0;
    // Masked during reset so a discarded response never looks valid.
    assign bus.rsp_valid  = ((r_state == RESP) && !reset) ? (NREQ'(1) << r_gid) : '0;
    assign bus.rsp_data   = r_data;
    assign bus.mux_select = r_sel;
    assign bus.busy       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_regfile_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_read_arbiter
// Description : Directed self-checking bench for regfile_read_arbiter. The
//               read mux is modelled as r[i] = 0xA000_0000 + i. Grants push
//               the expected response into a queue; completed response
//               handshakes pop and compare.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_read_arbiter;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];

    regfile_read_arbiter_if #(.DATA_W(32), .ADDR_W(5), .NREQ(4)) bus ();

    regfile_read_arbiter #(.DATA_W(32), .ADDR_W(5), .NREQ(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.mux_out = 32'hA000_0000 + {27'd0, bus.mux_select};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: completed handshakes are popped before new grants are
    // pushed, since both can happen in the same cycle.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if ((bus.rsp_valid & bus.rsp_ready) != 4'd0) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_rsp", {28'd0, bus.rsp_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_rsp_id", {28'd0, bus.rsp_valid}, {28'd0, e.id});
                    chk("sb_rsp_data", bus.rsp_data, e.data);
                end
            end
            for (int k = 0; k < 4; k++) begin
                if (bus.req_ready[k]) begin
                    exp_t e;
                    e.id   = 4'(1 << k);
                    e.data = 32'hA000_0000 + {27'd0, bus.req_addr[k*5 +: 5]};
                    exp_q.push_back(e);
                end
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    initial begin
        reset         = 1'b1;
        bus.req_valid = 4'd0;
        bus.req_addr  = '0;
        bus.rsp_ready = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        neg();
        chk("rst_req_ready", {28'd0, bus.req_ready}, 32'd0);
        chk("rst_rsp_valid", {28'd0, bus.rsp_valid}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_mux_select", {27'd0, bus.mux_select}, 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);

        // Single read of r7 by requester 0
        nxt();
        reset         = 1'b0;
        bus.rsp_ready = 4'hF;
        bus.req_valid = 4'b0001;
        bus.req_addr  = {5'd0, 5'd0, 5'd0, 5'd7};
        neg();
        chk("t1_grant", {28'd0, bus.req_ready}, 32'h1);
        nxt();
        bus.req_valid = 4'b0000;
        neg();
        chk("t1_mux_select", {27'd0, bus.mux_select}, 32'd7);
        chk("t1_capture_ready", {28'd0, bus.req_ready}, 32'd0);
        chk("t1_capture_rsp", {28'd0, bus.rsp_valid}, 32'd0);
        nxt();
        neg();
        chk("t1_rsp_valid", {28'd0, bus.rsp_valid}, 32'h1);
        chk("t1_rsp_data", bus.rsp_data, 32'hA000_0007);
        nxt();
        neg();
        chk("t1_idle", {31'd0, bus.busy}, 32'd0);

        // Round-robin with all requesters valid; reset first so ptr is 0
        nxt();
        reset = 1'b1;
        nxt();
        reset         = 1'b0;
        bus.req_valid = 4'hF;
        bus.req_addr  = {5'd4, 5'd3, 5'd2, 5'd1};
        for (int i = 0; i < 5; i++) begin
            neg();
            chk("rr_grant", {28'd0, bus.req_ready}, 32'(1 << (i % 4)));
            nxt();
            neg();
            chk("rr_gap", {28'd0, bus.req_ready}, 32'd0);
            nxt();
        end
        bus.req_valid = 4'd0;
        neg();
        chk("rr_last_rsp", {28'd0, bus.rsp_valid}, 32'h1);
        nxt();
        neg();
        chk("rr_idle", {31'd0, bus.busy}, 32'd0);

        // Backpressure: ptr is 1, so requester 2 wins over requester 0
        nxt();
        bus.rsp_ready = 4'd0;
        bus.req_valid = 4'b0101;
        bus.req_addr  = {5'd0, 5'd31, 5'd0, 5'd5};
        neg();
        chk("bp_grant2", {28'd0, bus.req_ready}, 32'h4);
        nxt();
        bus.req_valid = 4'b0001;
        neg();
        nxt();
        for (int i = 0; i < 5; i++) begin
            neg();
            chk("bp_hold_valid", {28'd0, bus.rsp_valid}, 32'h4);
            chk("bp_hold_data", bus.rsp_data, 32'hA000_001F);
            chk("bp_no_grant", {28'd0, bus.req_ready}, 32'd0);
            nxt();
        end
        bus.rsp_ready = 4'b0100;
        neg();
        chk("bp_grant0_same_cycle", {28'd0, bus.req_ready}, 32'h1);
        nxt();
        bus.req_valid = 4'd0;
        bus.rsp_ready = 4'd0;
        neg();
        nxt();
        bus.rsp_ready = 4'b0001;
        neg();
        chk("bp_rsp0", {28'd0, bus.rsp_valid}, 32'h1);
        nxt();
        neg();
        chk("bp_idle", {31'd0, bus.busy}, 32'd0);

        // Wrong-port ready: response for requester 1, only rsp_ready[3]
        nxt();
        bus.req_valid = 4'b0010;
        bus.req_addr  = {5'd0, 5'd0, 5'd9, 5'd0};
        neg();
        chk("wp_grant1", {28'd0, bus.req_ready}, 32'h2);
        nxt();
        bus.req_valid = 4'd0;
        bus.rsp_ready = 4'b1000;
        neg();
        nxt();
        for (int i = 0; i < 3; i++) begin
            neg();
            chk("wp_rsp_held", {28'd0, bus.rsp_valid}, 32'h2);
            chk("wp_busy", {31'd0, bus.busy}, 32'd1);
            nxt();
        end
        bus.rsp_ready = 4'b0010;
        neg();
        chk("wp_rsp_done", {28'd0, bus.rsp_valid}, 32'h2);
        nxt();
        bus.rsp_ready = 4'hF;
        neg();
        chk("wp_idle", {31'd0, bus.busy}, 32'd0);

        // Reset during CAPTURE (ptr is 2; grant requester 2, ptr -> 3)
        nxt();
        bus.req_valid = 4'b0100;
        bus.req_addr  = {5'd0, 5'd12, 5'd0, 5'd0};
        neg();
        chk("mr_grant2", {28'd0, bus.req_ready}, 32'h4);
        nxt();
        bus.req_valid = 4'd0;
        reset         = 1'b1;
        neg();
        nxt();
        reset = 1'b0;
        neg();
        chk("mr_rsp_valid", {28'd0, bus.rsp_valid}, 32'd0);
        chk("mr_busy", {31'd0, bus.busy}, 32'd0);
        chk("mr_mux_select", {27'd0, bus.mux_select}, 32'd0);
        chk("mr_rsp_data", bus.rsp_data, 32'd0);
        nxt();
        bus.req_valid = 4'b1001;
        bus.req_addr  = {5'd20, 5'd0, 5'd0, 5'd3};
        neg();
        chk("mr_ptr_restart", {28'd0, bus.req_ready}, 32'h1);
        nxt();
        bus.req_valid = 4'b1000;
        neg();
        nxt();
        neg();
        chk("mr_grant3", {28'd0, bus.req_ready}, 32'h8);
        chk("mr_rsp0", {28'd0, bus.rsp_valid}, 32'h1);

        // Pointer wrap: last grant was 3, now 0 and 3 both valid
        nxt();
        bus.req_valid = 4'd0;
        neg();
        nxt();
        bus.req_valid = 4'b1001;
        neg();
        chk("pw_grant0", {28'd0, bus.req_ready}, 32'h1);
        chk("pw_rsp3", {28'd0, bus.rsp_valid}, 32'h8);
        nxt();
        bus.req_valid = 4'b1000;
        neg();
        nxt();
        neg();
        chk("pw_grant3", {28'd0, bus.req_ready}, 32'h8);
        nxt();
        bus.req_valid = 4'd0;
        neg();
        nxt();
        neg();
        nxt();
        neg();
        chk("end_idle", {31'd0, bus.busy}, 32'd0);
        chk("end_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
